bcd_digit_sequencer: RTL and testbench

Sequential binary-to-BCD converter for the reaction-time display path. It accepts a 13-bit millisecond value and uses a combinational divide-by-ten quotient/remainder step once per clock to peel off four decimal digits, least significant first. Results go into a shadow register and are published atomically to the seven-segment driver, so the display never shows a partial result. A start/busy/done handshake sequences the conversion.

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_digit_sequencer_if.sv | 34 +++
 rtl/div10_step.sv | 21 ++
 rtl/bcd_digit_sequencer.sv | 119 +++++++++++
 tb/tb_bcd_digit_sequencer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD digit sequencer.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int DIGIT_W      = 4;
    localparam int DECIMAL_BASE = 10;

endpackage

// File: rtl/bcd_digit_sequencer_if.sv
// Start/busy/done handshake and published digit bus for the BCD sequencer.
interface bcd_digit_sequencer_if
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
) ();

    logic                        start;
    logic [WIDTH-1:0]            value;
    logic                        busy;
    logic                        done;
    logic [DIGITS*DIGIT_W-1:0]   digits;
    logic [DIGITS-1:0]           blank;

    modport master (
        output start,
        output value,
        input  busy,
        input  done,
        input  digits,
        input  blank
    );

    modport slave (
        input  start,
        input  value,
        output busy,
        output done,
        output digits,
        output blank
    );

endinterface

// File: rtl/div10_step.sv
// Combinational divide-by-ten step: quotient plus remainder (din - 10*quot).
module div10_step
    import bcd_pkg::*;
#(
    parameter int WIDTH = 13
) (
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   quot,
    output logic [DIGIT_W-1:0] rem
);

    logic [WIDTH-1:0] prod;

    always_comb begin
        quot = din / WIDTH'(DECIMAL_BASE);
        prod = quot * WIDTH'(DECIMAL_BASE);
        // The difference is always 0..9, so its low nibble is the whole remainder.
        rem  = DIGIT_W'(din - prod);
    end

endmodule

// File: rtl/bcd_digit_sequencer.sv
// Sequential binary-to-BCD converter, one digit per clock, atomic publish.
// Optional leading-zero blanking via BCD_LEADING_ZERO_BLANK_EN.
module bcd_digit_sequencer
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_digit_sequencer_if.slave  bus
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW    = DIGITS * DIGIT_W;

    state_t               state;
    logic [WIDTH-1:0]     work;
    logic [IDX_W-1:0]     idx;
    logic [DW-1:0]        shadow;
    logic [DW-1:0]        shadow_next;
    logic [WIDTH-1:0]     quot;
    logic [DIGIT_W-1:0]   rem;
    logic                 busy_q;
    logic                 done_q;
    logic [DW-1:0]        digits_q;
    logic                 last_step;

    div10_step #(.WIDTH(WIDTH)) u_div (
        .din  (work),
        .quot (quot),
        .rem  (rem)
    );

    // Publish from the shadow as it will look after this edge, so the final digit is included.
    always_comb begin
        shadow_next = shadow;
        shadow_next[int'(idx)*DIGIT_W +: DIGIT_W] = rem;
        last_step = (state == CONVERT) && (idx == IDX_W'(DIGITS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            work     <= '0;
            idx      <= '0;
            shadow   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        work   <= bus.value;
                        idx    <= '0;
                        shadow <= '0;
                        busy_q <= 1'b1;
                        state  <= CONVERT;
                    end
                end
                CONVERT: begin
                    shadow <= shadow_next;
                    work   <= quot;
                    idx    <= idx + 1'b1;
                    if (last_step) begin
                        digits_q <= shadow_next;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.digits = digits_q;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_next;
    logic              zero_run;

    // Walk down from the top digit; a digit blanks while everything above it is zero too.
    always_comb begin
        blank_next = '0;
        zero_run   = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (shadow_next[i*DIGIT_W +: DIGIT_W] == '0);
            blank_next[i] = zero_run;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else if (last_step) begin
            blank_q <= blank_next;
        end
    end

    assign bus.blank = blank_q;
`else
    assign bus.blank = '0;
`endif

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Directed table-driven bench for bcd_digit_sequencer plus multi-cycle corner sequences.
module tb_bcd_digit_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_digit_sequencer_if #(.WIDTH(13), .DIGITS(4)) bus ();

    bcd_digit_sequencer #(.WIDTH(13), .DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [12:0] value;
        logic [15:0] exp_digits;
        logic [3:0]  exp_blank_on;
    } vec_t;

    vec_t        vecs[10];
    logic [12:0] bvals[4];
    logic [15:0] bexp[4];

    function automatic logic [3:0] exp_blank(input logic [3:0] on);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        return on;
`else
        return 4'b0000;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_conv(input string name, input logic [12:0] v,
                            input logic [15:0] ed, input logic [3:0] eb);
        int   n;
        logic seen;
        bus.start = 1'b1;
        bus.value = v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.value = ~v;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) check({name, ".busy_rise"}, {31'd0, bus.busy}, 32'd1);
            if (bus.done) seen = 1'b1;
        end
        check({name, ".latency"}, n, 32'd5);
        check({name, ".digits"}, {16'd0, bus.digits}, {16'd0, ed});
        check({name, ".blank"}, {28'd0, bus.blank}, {28'd0, exp_blank(eb)});
        @(negedge clk);
        check({name, ".done_one_cycle"}, {31'd0, bus.done}, 32'd0);
        check({name, ".busy_fall"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] prev;
        logic        unstable;
        int          dcount;

        vecs[0] = '{13'd1234, 16'h1234, 4'b0000};
        vecs[1] = '{13'd8191, 16'h8191, 4'b0000};
        vecs[2] = '{13'd0,    16'h0000, 4'b1110};
        vecs[3] = '{13'd507,  16'h0507, 4'b1000};
        vecs[4] = '{13'd42,   16'h0042, 4'b1100};
        vecs[5] = '{13'd9,    16'h0009, 4'b1110};
        vecs[6] = '{13'd10,   16'h0010, 4'b1100};
        vecs[7] = '{13'd100,  16'h0100, 4'b1000};
        vecs[8] = '{13'd1000, 16'h1000, 4'b0000};
        vecs[9] = '{13'd7006, 16'h7006, 4'b0000};
        bvals[0] = 13'd9;   bexp[0] = 16'h0009;
        bvals[1] = 13'd10;  bexp[1] = 16'h0010;
        bvals[2] = 13'd99;  bexp[2] = 16'h0099;
        bvals[3] = 13'd100; bexp[3] = 16'h0100;

        bus.start = 1'b0;
        bus.value = '0;
        #12;
        check("reset.busy",   {31'd0, bus.busy},    32'd0);
        check("reset.done",   {31'd0, bus.done},    32'd0);
        check("reset.digits", {16'd0, bus.digits},  32'd0);
        check("reset.blank",  {28'd0, bus.blank},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].value, vecs[i].exp_digits, vecs[i].exp_blank_on);
        end

        // start pulsed mid-conversion with another value must be ignored
        bus.start = 1'b1;
        bus.value = 13'd1234;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dcount = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 2) begin
                bus.start = 1'b1;
                bus.value = 13'd999;
            end
            if (n == 3) bus.start = 1'b0;
            if (bus.done) dcount++;
        end
        check("ignore.done_count", dcount, 32'd1);
        check("ignore.digits", {16'd0, bus.digits}, 32'h1234);

        // reset during the third CONVERT cycle clears published digits immediately
        bus.start = 1'b1;
        bus.value = 13'd4321;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid.busy_before", {31'd0, bus.busy}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid.busy",   {31'd0, bus.busy},   32'd0);
        check("rst_mid.done",   {31'd0, bus.done},   32'd0);
        check("rst_mid.digits", {16'd0, bus.digits}, 32'd0);
        check("rst_mid.blank",  {28'd0, bus.blank},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_conv("after_rst", 13'd507, 16'h0507, 4'b1000);

        // start held high: back-to-back conversions every 6 cycles
        prev     = bus.digits;
        unstable = 1'b0;
        dcount   = 0;
        bus.value = bvals[0];
        bus.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (k < 3) bus.value = bvals[k+1];
            else bus.start = 1'b0;
            for (int n = 1; n <= 6; n++) begin
                @(negedge clk);
                if (bus.done) begin
                    dcount++;
                    check($sformatf("b2b%0d.latency", k), n, 32'd5);
                    check($sformatf("b2b%0d.digits", k), {16'd0, bus.digits}, {16'd0, bexp[k]});
                    prev = bus.digits;
                end else if (bus.digits !== prev) begin
                    unstable = 1'b1;
                end
                if (n == 6) check($sformatf("b2b%0d.idle_gap", k), {31'd0, bus.busy}, 32'd0);
            end
        end
        check("b2b.done_count", dcount, 32'd4);
        check("b2b.digits_stable", {31'd0, unstable}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
